coreriscv_axi4_manager_acquire_arbiter: RTL

//  Shares one TileLink manager Acquire channel between N_CLIENTS client-side Acquire sources.

---
 rtl/coreriscv_axi4_tl_pkg.sv | 50 +++++
 rtl/coreriscv_axi4_manager_acquire_arbiter_if.sv | 27 ++
 rtl/coreriscv_axi4_rr_pick.sv | 26 ++
 rtl/coreriscv_axi4_manager_acquire_arbiter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/coreriscv_axi4_tl_pkg.sv
// TileLink Acquire payload layout, a_type encodings and arbiter state type.
package coreriscv_axi4_tl_pkg;

    localparam int unsigned BLOCK_W = 26;
    localparam int unsigned XID_W   = 1;
    localparam int unsigned BEAT_W  = 3;
    localparam int unsigned ATYPE_W = 3;
    localparam int unsigned UNION_W = 12;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned ACQ_W   = BLOCK_W + XID_W + BEAT_W + 1 + ATYPE_W + UNION_W + DATA_W;
    localparam int unsigned BEATS   = 8;

    // Field LSB offsets inside the packed payload.
    localparam int unsigned DATA_LSB    = 0;
    localparam int unsigned UNION_LSB   = DATA_LSB + DATA_W;
    localparam int unsigned ATYPE_LSB   = UNION_LSB + UNION_W;
    localparam int unsigned BUILTIN_LSB = ATYPE_LSB + ATYPE_W;
    localparam int unsigned BEAT_LSB    = BUILTIN_LSB + 1;
    localparam int unsigned XID_LSB     = BEAT_LSB + BEAT_W;
    localparam int unsigned BLOCK_LSB   = XID_LSB + XID_W;

    typedef enum logic [ATYPE_W-1:0] {
        A_GET        = 3'h0,
        A_GET_BLOCK  = 3'h1,
        A_PUT        = 3'h2,
        A_PUT_BLOCK  = 3'h3,
        A_PUT_ATOMIC = 3'h4
    } a_type_e;

    typedef struct packed {
        logic [BLOCK_W-1:0] addr_block;
        logic [XID_W-1:0]   client_xact_id;
        logic [BEAT_W-1:0]  addr_beat;
        logic               is_builtin_type;
        logic [ATYPE_W-1:0] a_type;
        logic [UNION_W-1:0] union_bits;
        logic [DATA_W-1:0]  data;
    } acquire_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // A built-in PutBlock is the only message that spans several beats.
    function automatic logic is_multibeat(input acquire_t acq);
        return acq.is_builtin_type && (acq.a_type == ATYPE_W'(A_PUT_BLOCK));
    endfunction

endpackage

// File: rtl/coreriscv_axi4_manager_acquire_arbiter_if.sv
// Client-side Acquire sources and manager-side Acquire sink bundled together.
interface coreriscv_axi4_manager_acquire_arbiter_if
    import coreriscv_axi4_tl_pkg::*;
#(
    parameter int unsigned N_CLIENTS = 2,
    parameter int unsigned CID_W     = 1
);
    logic [N_CLIENTS-1:0]       in_valid;
    logic [N_CLIENTS-1:0]       in_ready;
    logic [N_CLIENTS*ACQ_W-1:0] in_bits;
    logic                       out_valid;
    logic                       out_ready;
    logic [ACQ_W-1:0]           out_bits;
    logic [CID_W-1:0]           out_client_id;

    // Environment side: drives client requests and manager ready.
    modport master (
        output in_valid, in_bits, out_ready,
        input  in_ready, out_valid, out_bits, out_client_id
    );

    // Arbiter side.
    modport slave (
        input  in_valid, in_bits, out_ready,
        output in_ready, out_valid, out_bits, out_client_id
    );
endinterface

// File: rtl/coreriscv_axi4_rr_pick.sv
// Round-robin first-one picker: first requester after last_i, wrapping modulo N.
module coreriscv_axi4_rr_pick
    import coreriscv_axi4_tl_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] grant_o,
    output logic             any_o
);

    // Scan last+1, last+2, ... and keep the first requester found.
    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            if (!any_o && req_i[(32'(last_i) + k) % N]) begin
                grant_o = IDX_W'((32'(last_i) + k) % N);
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/coreriscv_axi4_manager_acquire_arbiter.sv
// Shares one manager Acquire channel among N_CLIENTS sources with per-message
// round-robin; a PutBlock keeps the channel until its last beat.
// Optional feature macro: ACQ_ARB_BEAT_CHECK_EN (sticky addr_beat sequence check).
module coreriscv_axi4_manager_acquire_arbiter
    import coreriscv_axi4_tl_pkg::*;
#(
    parameter int unsigned N_CLIENTS = 2,
    parameter int unsigned CID_W     = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1
) (
    input  logic clk,
    input  logic reset,
    coreriscv_axi4_manager_acquire_arbiter_if.slave bus,
    output logic err_beat
);

    arb_state_e        state_q, state_d;
    logic [CID_W-1:0]  lock_id_q, lock_id_d;
    logic [CID_W-1:0]  rr_last_q, rr_last_d;
    logic [CID_W-1:0]  hold_id_q, hold_id_d;
    logic              hold_q, hold_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CID_W-1:0]  pick_idx;
    logic              pick_any;
    logic [CID_W-1:0]  winner;
    acquire_t          win_acq;
    logic              hs;

    coreriscv_axi4_rr_pick #(
        .N     (N_CLIENTS),
        .IDX_W (CID_W)
    ) u_rr_pick (
        .req_i   (bus.in_valid),
        .last_i  (rr_last_q),
        .grant_o (pick_idx),
        .any_o   (pick_any)
    );

    // Winner: locked owner, else an offered-but-unaccepted client, else fresh pick.
    always_comb begin
        winner = pick_idx;
        if (state_q == ST_LOCKED) begin
            winner = lock_id_q;
        end else if (hold_q && bus.in_valid[hold_id_q]) begin
            winner = hold_id_q;
        end
    end

    assign win_acq = acquire_t'(bus.in_bits[32'(winner) * ACQ_W +: ACQ_W]);

    // Next-state and combinational channel outputs; all quiet while reset is high.
    always_comb begin
        state_d           = state_q;
        lock_id_d         = lock_id_q;
        rr_last_d         = rr_last_q;
        beat_cnt_d        = beat_cnt_q;
        hold_d            = 1'b0;
        hold_id_d         = hold_id_q;
        hs                = 1'b0;
        bus.out_valid     = 1'b0;
        bus.in_ready      = '0;
        bus.out_bits      = '0;
        bus.out_client_id = '0;
        if (!reset) begin
            bus.out_bits      = win_acq;
            bus.out_client_id = winner;
            case (state_q)
                ST_IDLE: begin
                    bus.out_valid        = pick_any;
                    bus.in_ready[winner] = bus.out_ready;
                    hs                   = pick_any && bus.out_ready;
                    hold_d               = pick_any && !bus.out_ready;
                    hold_id_d            = winner;
                    if (hs) begin
                        rr_last_d = winner;
                        if (is_multibeat(win_acq)) begin
                            state_d    = ST_LOCKED;
                            lock_id_d  = winner;
                            beat_cnt_d = BEAT_W'(1);
                        end
                    end
                end
                ST_LOCKED: begin
                    bus.out_valid           = bus.in_valid[lock_id_q];
                    bus.in_ready[lock_id_q] = bus.out_ready;
                    hs                      = bus.in_valid[lock_id_q] && bus.out_ready;
                    if (hs) begin
                        if (beat_cnt_q == BEAT_W'(BEATS - 1)) begin
                            state_d    = ST_IDLE;
                            beat_cnt_d = '0;
                        end else begin
                            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State registers; reset points the round-robin so client 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            lock_id_q  <= '0;
            rr_last_q  <= CID_W'(N_CLIENTS - 1);
            beat_cnt_q <= '0;
            hold_q     <= 1'b0;
            hold_id_q  <= '0;
        end else begin
            state_q    <= state_d;
            lock_id_q  <= lock_id_d;
            rr_last_q  <= rr_last_d;
            beat_cnt_q <= beat_cnt_d;
            hold_q     <= hold_d;
            hold_id_q  <= hold_id_d;
        end
    end

`ifdef ACQ_ARB_BEAT_CHECK_EN
    logic              err_q;
    logic [BEAT_W-1:0] exp_beat;

    assign exp_beat = (state_q == ST_LOCKED) ? beat_cnt_q : '0;

    // Sticky flag: an accepted beat carried an out-of-sequence addr_beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (hs && (win_acq.addr_beat != exp_beat)) begin
            err_q <= 1'b1;
        end
    end

    assign err_beat = err_q;
`else
    assign err_beat = 1'b0;
`endif

endmodule
